// File: rtl/display_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// | display_pkg                                                             |
// | Shared widths, FSM state encoding and index-width helper for the        |
// | display arbiter.                                                        |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package display_pkg;

  localparam int DISP_W  = 32;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OPEN = 2'd2
  } state_e;

  // Keeps a one-bit index even where $clog2 would return zero.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_arbiter_if.sv
// ---------------------------------------------------------------------------
// | display_arbiter_if                                                      |
// | Requester-side bus of the display arbiter: requests, words, grant.      |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

interface display_arbiter_if
  import display_pkg::*;
#(
  parameter int N_REQ = 4
);

  localparam int IW = idx_w(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [DISP_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic [IW-1:0]           owner;
  logic                    busy;
  logic [DISP_W:1]         data;

  modport master (
    output req, req_data,
    input  gnt, owner, busy, data
  );

  modport slave (
    input  req, req_data,
    output gnt, owner, busy, data
  );

endinterface

`default_nettype wire

// File: rtl/display_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// | rr_picker                                                               |
// | Combinational round-robin search from ptr with optional exclusion.      |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module rr_picker
  import display_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_w(N_REQ)
) (
  input  wire logic [N_REQ-1:0] req_i,
  input  wire logic [IW-1:0]    ptr_i,
  input  wire logic [IW-1:0]    excl_i,
  input  wire logic             excl_en_i,
  output logic      [N_REQ-1:0] onehot_o,
  output logic      [IW-1:0]    idx_o,
  output logic                  valid_o
);

  logic [N_REQ-1:0] masked_w;

  for (genvar i = 0; i < N_REQ; i++) begin : g_mask
    assign masked_w[i] = req_i[i] && !(excl_en_i && (excl_i == IW'(i)));
  end

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = (int'(ptr_i) + k) % N_REQ;
      if (!valid_o && masked_w[j]) begin
        valid_o     = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = IW'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/display_arbiter.sv
// ---------------------------------------------------------------------------
// | display_arbiter                                                         |
// | Round-robin owner of the scan display with a minimum hold per grant.    |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module display_arbiter
  import display_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 1024,
  parameter int HOLD_W      = 11
) (
  input wire logic         clk,
  input wire logic         rst_n,
  display_arbiter_if.slave bus
);

  localparam int IW = idx_w(N_REQ);

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic                busy_q, busy_d;
  logic [DISP_W:1]     data_q, data_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]       ptr_q, ptr_d;

  logic [N_REQ-1:0]    pick_onehot_w;
  logic [IW-1:0]       pick_idx_w;
  logic                pick_valid_w;
  logic                own_req_w;
  logic                cnt_zero_w;
  logic                do_grant_w;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .excl_i    (owner_q),
    .excl_en_i (busy_q),
    .onehot_o  (pick_onehot_w),
    .idx_o     (pick_idx_w),
    .valid_o   (pick_valid_w)
  );

  assign own_req_w  = |(gnt_q & bus.req);
  assign cnt_zero_w = (cnt_q == '0);
  assign do_grant_w = pick_valid_w &&
                      ((state_q == IDLE) || (state_q == OPEN) ||
                       ((state_q == HOLD) && cnt_zero_w));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pick_valid_w) state_d = HOLD;
      HOLD: begin
        if (cnt_zero_w) begin
          if (pick_valid_w)   state_d = HOLD;
          else if (own_req_w) state_d = OPEN;
          else                state_d = IDLE;
        end
      end
      OPEN: begin
        if (pick_valid_w)    state_d = HOLD;
        else if (!own_req_w) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new grant takes priority over live tracking of the previous owner.
  always_comb begin
    gnt_d   = gnt_q;
    owner_d = owner_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    busy_d  = (state_d != IDLE);
    if ((state_q == HOLD) && !cnt_zero_w) cnt_d = cnt_q - HOLD_W'(1);
    if (do_grant_w) begin
      gnt_d   = pick_onehot_w;
      owner_d = pick_idx_w;
      data_d  = bus.req_data[DISP_W*int'(pick_idx_w) +: DISP_W];
      cnt_d   = HOLD_W'(HOLD_CYCLES - 1);
      ptr_d   = (pick_idx_w == IW'(N_REQ - 1)) ? '0 : pick_idx_w + IW'(1);
    end else if (state_d == IDLE) begin
      gnt_d = '0;
    end else if (own_req_w) begin
      data_d = bus.req_data[DISP_W*int'(owner_q) +: DISP_W];
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
  assign bus.data  = data_q;

endmodule

`default_nettype wire

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single 8-digit seven-segment scan display between up to N_REQ requesters, such as the register viewer, ALU result and PC monitor.
- Arbitrates by round-robin with a guaranteed minimum on-screen time per grant, so a value stays readable.
- Drives the 32-bit data word consumed by the Display scan module, and reports which requester owns the display.

Parameters:
N_REQ, 4, number of requesters; legal range 2..8
HOLD_CYCLES, 1024, minimum clk cycles a grant is held; legal range 1..2^HOLD_W-1
HOLD_W, 11, width of the hold counter

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  reset, synchronous, active-low
req  input  N_REQ  request per requester; level-sensitive
req_data  input  32*N_REQ  packed display words; requester i occupies bits [32*i+31:32*i]
gnt  output  N_REQ  one-hot grant, registered
owner  output  $clog2(N_REQ)  binary index of the current or last owner
busy  output  1  high while any grant is active
data  output  32 ([32:1])  word to the Display data input; bit 32 is the MSB of digit 7

Behaviour:
- Reset (rst_n low at a clk edge): gnt=0, owner=0, busy=0, data=0, hold counter=0, round-robin pointer=0, state=IDLE.
  - Reset asserted mid-HOLD or mid-OPEN clears everything on that same edge; no grant survives.
- Round-robin pick:
  - Search req starting at index ptr, wrapping modulo N_REQ; the first set bit wins.
  - On every new grant, ptr <= winner+1 mod N_REQ.
  - When switching owners, the current owner's bit is masked out of the search.
- State IDLE:
  - gnt=0, busy=0; data and owner hold their last values.
  - If any req is set at edge t: gnt <= onehot(winner), owner <= winner, data <= req_data[winner], counter <= HOLD_CYCLES-1, go to HOLD.
  - Grant and data are therefore visible at t+1, a one-cycle latency.
- State HOLD:
  - The grant is fixed regardless of req.
  - If counter>0: decrement.
  - If counter==0, evaluate at that edge:
    - Another req is pending: switch directly to the round-robin winner among the others; reload the counter; stay in HOLD; no gap cycle between grants.
    - Otherwise, if the owner's req is still high: go to OPEN.
    - Otherwise: go to IDLE and clear gnt and busy on that edge.
  - Grant tenure under contention is therefore exactly HOLD_CYCLES cycles.
- State OPEN: the owner keeps the grant indefinitely while its req is high and no other req is set.
  - Any other req set at an edge: switch as in HOLD and go to HOLD.
  - Owner req low with no other req: go to IDLE.
  - Owner req low with another req pending: switch to that requester and go to HOLD.
- Data path:
  - Each edge where gnt[i] && req[i]: data <= req_data[i], so data tracks the owner live with a one-cycle lag.
  - If the owner drops req while still granted (in HOLD), data freezes at the last sampled word.
- busy = (state != IDLE); it is registered alongside gnt.
- Invariants:
  - gnt is always one-hot or zero.
  - owner always equals the index of the set gnt bit when busy=1.
- The counter never underflows; it is only reloaded on a new grant.

Decomposition:
- Shared package display_pkg:
  - DISP_W=32.
  - MAX_REQ=8.
  - state enum {IDLE, HOLD, OPEN}.
  - function for the owner index width.
- One sub-module, rr_picker (combinational):
  - Inputs: req mask, ptr, exclude index, exclude enable.
  - Outputs: one-hot winner, binary index, any_valid.

Test Plan (HOLD_CYCLES=8, N_REQ=4):
1. Reset:
   - rst_n=0 for 3 cycles with req=4'b1111 -> gnt=0, data=0, busy=0, owner=0.
   - Release rst_n -> next edge gnt=4'b0001, data=req_data[0].
2. Single request:
   - req[2] rises at t with req_data[2]=32'hfedc_ba98 -> at t+1 gnt=4'b0100, owner=2, data=32'hfedcba98.
   - req[2] drops at t+3 -> gnt held through t+8, data frozen at 32'hfedcba98.
   - At t+9: gnt=0, busy=0, data still 32'hfedcba98.
3. Contention:
   - req[0] granted at t+1; req[1] (32'h7654_3210) rises at t+2 -> gnt[0] held exactly 8 cycles.
   - At t+9: gnt=4'b0010, data=32'h76543210, with no idle cycle in between.
4. Full rotation: req=4'b1111 held -> grant order 0,1,2,3,0, each tenure exactly 8 cycles; owner steps 0,1,2,3,0.
5. Live update: owner 1 holds req in OPEN while req_data[1] increments every cycle -> data equals the previous cycle's req_data[1] on every cycle.
6. Reset mid-HOLD: rst_n low at counter=4 -> next edge gnt=0, data=0, ptr=0; with req=4'b1010 after release, requester 1 wins first.
